mips_div_unit: RTL and testbench

Iterative 32-bit radix-2 divider serving MIPS DIV/DIVU in the EXE stage. It is the stall source behind the ID/EXE register's `is_div_block` / `is_divu_block` inputs: while an EXE-stage divide is unfinished it holds the stage, then presents quotient (LO) and remainder (HI). The result is held until the instruction leaves EXE.

---
 rtl/mips_div_unit_pkg.sv | 23 ++
 rtl/mips_div_unit_div_step.sv | 37 +++
 rtl/mips_div_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mips_div_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mips_div_unit_pkg
// Purpose : shared definitions for the iterative MIPS DIV/DIVU unit.
//           Holds the divider FSM state encoding, the default operand width
//           and the quotient returned for an unsigned divide by zero.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mips_div_unit_pkg;

  // Divider control states: idle/latching, iterating, result held
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Default operand width; the iteration count follows it
  localparam int DIV_W_DEFAULT = 32;

  // Quotient produced by an unsigned divide by zero (all ones)
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_div_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// Purpose : one combinational restoring-division iteration. The partial
//           remainder and quotient/dividend register are shifted left as a
//           pair, the divisor is trial-subtracted from the widened remainder
//           and the new quotient bit is set when the subtraction does not
//           borrow.
// Ports   : i_rem     - partial remainder entering this step
//           i_quot    - quotient/dividend shift register entering this step
//           i_divisor - divisor magnitude
//           o_rem     - partial remainder after this step
//           o_quot    - quotient/dividend shift register after this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quot,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quot
);

  logic [W:0] w_trial;
  logic       w_noBorrow;

  // The shifted remainder can need W+1 bits before the subtraction, so the
  // trial value keeps the extra top bit. After a successful subtraction the
  // result is always below the divisor and fits back into W bits.
  always_comb begin
    w_trial    = {i_rem, i_quot[W-1]};
    w_noBorrow = (w_trial >= {1'b0, i_divisor});
    o_rem      = w_noBorrow ? W'(w_trial - {1'b0, i_divisor}) : w_trial[W-1:0];
    o_quot     = {i_quot[W-2:0], w_noBorrow};
  end

endmodule

// File: rtl/mips_div_unit.sv
// -----------------------------------------------------------------------------
// mips_div_unit
// Purpose : iterative radix-2 restoring divider for MIPS DIV (signed) and
//           DIVU (unsigned) in the EXE stage. It stalls the stage while a
//           divide is in flight, then holds quotient (LO) and remainder (HI)
//           until the instruction leaves EXE.
// Config  : define DIV_ZERO_FAST_EN to finish a divide by zero in one cycle
//           instead of running every iteration.
// Ports   : clk           - rising-edge clock
//           reset         - synchronous, active-high
//           div_req       - signed DIV valid in EXE
//           divu_req      - unsigned DIVU valid in EXE
//           src1 / src2   - dividend (rs) / divisor (rt)
//           exe_leave     - EXE instruction handed to MEM
//           flush         - exception/ERET flush, aborts any divide
//           is_div_block  - stall, signed divide pending
//           is_divu_block - stall, unsigned divide pending
//           div_done      - result valid and held
//           quot / rem    - quotient (LO) / remainder (HI)
// -----------------------------------------------------------------------------
module mips_div_unit
  import mips_div_unit_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic             divu_req,
  input  logic [DIV_W-1:0] src1,
  input  logic [DIV_W-1:0] src2,
  input  logic             exe_leave,
  input  logic             flush,
  output logic             is_div_block,
  output logic             is_divu_block,
  output logic             div_done,
  output logic [DIV_W-1:0] quot,
  output logic [DIV_W-1:0] rem
);

  localparam int CNT_W = $clog2(DIV_W);

  div_state_e       r_state;
  div_state_e       w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [DIV_W-1:0] r_remAcc;
  logic [DIV_W-1:0] r_quotAcc;
  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W-1:0] r_quot;
  logic [DIV_W-1:0] r_rem;
  logic             r_signed;
  logic             r_src1Sign;
  logic             r_src2Sign;

  logic             w_req;
  logic             w_lastIter;
  logic             w_quotNeg;
  logic             w_remNeg;
  logic [DIV_W-1:0] w_src1Mag;
  logic [DIV_W-1:0] w_src2Mag;
  logic [DIV_W-1:0] w_stepRem;
  logic [DIV_W-1:0] w_stepQuot;
  logic [DIV_W-1:0] w_finalQuot;
  logic [DIV_W-1:0] w_finalRem;
`ifdef DIV_ZERO_FAST_EN
  logic             w_zeroDiv;
  logic [DIV_W-1:0] w_zeroQuot;
`endif

  // Operand magnitudes: only a signed DIV takes the absolute value, DIVU
  // divides the raw bit patterns.
  assign w_req     = div_req | divu_req;
  assign w_src1Mag = (div_req & src1[DIV_W-1]) ? -src1 : src1;
  assign w_src2Mag = (div_req & src2[DIV_W-1]) ? -src2 : src2;

  // Sign fix-up of the final magnitudes. The remainder follows the dividend,
  // the quotient is negative when the operand signs differ. Negating
  // 0x80000000 gives itself, which is exactly the MIN/-1 overflow result.
  assign w_quotNeg   = r_signed & (r_src1Sign ^ r_src2Sign);
  assign w_remNeg    = r_signed & r_src1Sign;
  assign w_lastIter  = (r_count == CNT_W'(DIV_W - 1));
  assign w_finalQuot = w_quotNeg ? -w_stepQuot : w_stepQuot;
  assign w_finalRem  = w_remNeg  ? -w_stepRem  : w_stepRem;

`ifdef DIV_ZERO_FAST_EN
  // Divide by zero shortcut: the restoring loop would produce all-ones
  // magnitude and the dividend as remainder, so after the sign fix that is
  // 1 for a negative signed dividend, all ones otherwise, and rem = src1.
  assign w_zeroDiv  = (src2 == '0);
  assign w_zeroQuot = (div_req & src1[DIV_W-1]) ? DIV_W'(1) : DIV_W'(DIV_ZERO_Q);
`endif

  div_step #(
    .W         (DIV_W)
  ) u_divStep (
    .i_rem     (r_remAcc),
    .i_quot    (r_quotAcc),
    .i_divisor (r_divisor),
    .o_rem     (w_stepRem),
    .o_quot    (w_stepQuot)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Flush wins over everything, including a fresh request
  // in IDLE and exe_leave in DONE. DONE waits for exe_leave so a request that
  // stays high while MEM stalls does not start a second divide.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_req) begin
`ifdef DIV_ZERO_FAST_EN
            w_nextState = w_zeroDiv ? DIV_DONE : DIV_BUSY;
`else
            w_nextState = DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          if (w_lastIter) begin
            w_nextState = DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (exe_leave) begin
            w_nextState = DIV_IDLE;
          end
        end
        default: w_nextState = DIV_IDLE;
      endcase
    end
  end

  // Outputs. The stall signals are purely combinational on the request so the
  // pipeline is held in the very cycle the divide first reaches EXE.
  always_comb begin
    is_div_block  = div_req  & (r_state != DIV_DONE);
    is_divu_block = divu_req & (r_state != DIV_DONE);
    div_done      = (r_state == DIV_DONE);
    quot          = r_quot;
    rem           = r_rem;
  end

  // Datapath: operands are captured only in IDLE, one restoring step runs per
  // BUSY cycle, and the sign-fixed result is registered on the last step. A
  // flush leaves every register untouched, so an aborted divide never
  // overwrites the previously held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_remAcc   <= '0;
      r_quotAcc  <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_signed   <= 1'b0;
      r_src1Sign <= 1'b0;
      r_src2Sign <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        DIV_IDLE: begin
          if (w_req) begin
            r_count    <= '0;
            r_remAcc   <= '0;
            r_quotAcc  <= w_src1Mag;
            r_divisor  <= w_src2Mag;
            r_signed   <= div_req;
            r_src1Sign <= src1[DIV_W-1];
            r_src2Sign <= src2[DIV_W-1];
`ifdef DIV_ZERO_FAST_EN
            if (w_zeroDiv) begin
              r_quot <= w_zeroQuot;
              r_rem  <= src1;
            end
`endif
          end
        end
        DIV_BUSY: begin
          r_remAcc  <= w_stepRem;
          r_quotAcc <= w_stepQuot;
          r_count   <= r_count + CNT_W'(1);
          if (w_lastIter) begin
            r_quot <= w_finalQuot;
            r_rem  <= w_finalRem;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_div_unit
// Purpose : self-checking bench for mips_div_unit. Directed vectors from a
//           table, hand-written multi-cycle sequences (MEM stall, back-to-back,
//           flush, reset) and randomized divides compared against a plain
//           arithmetic reference model.
// Config  : honours DIV_ZERO_FAST_EN for the expected divide-by-zero latency.
// -----------------------------------------------------------------------------
module tb_mips_div_unit;
  import mips_div_unit_pkg::*;

  localparam int W        = 32;
  localparam int FULL_LAT = W + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  typedef struct {
    bit          isSigned;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_req;
  logic         divu_req;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         exe_leave;
  logic         flush;
  logic         is_div_block;
  logic         is_divu_block;
  logic         div_done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;

  int nCompared   = 0;
  int nMismatched = 0;

  mips_div_unit #(
    .DIV_W         (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .div_req       (div_req),
    .divu_req      (divu_req),
    .src1          (src1),
    .src2          (src2),
    .exe_leave     (exe_leave),
    .flush         (flush),
    .is_div_block  (is_div_block),
    .is_divu_block (is_divu_block),
    .div_done      (div_done),
    .quot          (quot),
    .rem           (rem)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Global time limit so a stuck design still ends with a report
  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model straight from the MIPS divide rules
  function automatic void refDiv(input bit isSigned, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] q,
                                 output logic [31:0] r);
    if (b == 32'd0) begin
      r = a;
      q = (isSigned && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (isSigned) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Present a divide to EXE just after a rising edge
  task automatic applyStimulus(input bit isSigned, input logic [31:0] a,
                               input logic [31:0] b);
    @(posedge clk);
    #1;
    div_req   = isSigned;
    divu_req  = !isSigned;
    src1      = a;
    src2      = b;
    exe_leave = 1'b0;
  endtask

  // Count stall cycles (sampled at falling edges) until div_done. Optionally
  // scramble the operands after the latch cycle to show they are ignored.
  task automatic waitDone(input bit isSigned, input bit scramble, output int lat);
    int guard;
    guard = 0;
    lat   = 0;
    @(negedge clk);
    while (!div_done && guard < 200) begin
      if (isSigned ? is_div_block : is_divu_block) lat++;
      if (scramble && guard > 0) begin
        src1 = $urandom;
        src2 = $urandom;
      end
      guard++;
      @(negedge clk);
    end
    if (!div_done) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  // Hand the instruction to MEM and drop the request
  task automatic leaveExe();
    @(posedge clk);
    #1 exe_leave = 1'b1;
    @(posedge clk);
    #1;
    exe_leave = 1'b0;
    div_req   = 1'b0;
    divu_req  = 1'b0;
  endtask

  // Full divide: issue, wait, compare result, latency and stall release
  task automatic runCase(input string name, input bit isSigned,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expQ, input logic [31:0] expR,
                         input bit scramble);
    int lat;
    int expLat;
    expLat = (b == 32'd0) ? ZERO_LAT : FULL_LAT;
    applyStimulus(isSigned, a, b);
    waitDone(isSigned, scramble, lat);
    checkOutput({name, " quot"}, quot, expQ);
    checkOutput({name, " rem"}, rem, expR);
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " blockAtDone"}, 32'(is_div_block | is_divu_block), 32'd0);
    leaveExe();
  endtask

  // Abort check: after the abort, no result may appear and outputs hold
  task automatic checkAborted(input string name, input logic [31:0] holdQ,
                              input logic [31:0] holdR);
    int doneSeen;
    doneSeen = 0;
    @(negedge clk);
    checkOutput({name, " block"}, 32'(is_div_block | is_divu_block), 32'd0);
    checkOutput({name, " done"}, 32'(div_done), 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (div_done) doneSeen++;
    end
    checkOutput({name, " noLateDone"}, 32'(doneSeen), 32'd0);
    checkOutput({name, " quotHeld"}, quot, holdQ);
    checkOutput({name, " remHeld"}, rem, holdR);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] holdQ;
    logic [31:0] holdR;
    bit          sgn;
    int          lat;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{1'b0, 32'd5,          32'd0,          DIV_ZERO_Q,     32'd5};
    vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};
    vecs[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

    reset     = 1'b1;
    div_req   = 1'b0;
    divu_req  = 1'b0;
    src1      = '0;
    src2      = '0;
    exe_leave = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("reset done", 32'(div_done), 32'd0);
    checkOutput("reset quot", quot, 32'd0);
    checkOutput("reset rem", rem, 32'd0);
    checkOutput("reset block", 32'(is_div_block | is_divu_block), 32'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      runCase($sformatf("vec%0d", i), vecs[i].isSigned, vecs[i].a, vecs[i].b,
              vecs[i].q, vecs[i].r, 1'b0);
    end

    // MEM stall after completion, then an immediate second DIVU
    applyStimulus(1'b0, 32'd100, 32'd7);
    waitDone(1'b0, 1'b0, lat);
    checkOutput("stall first latency", 32'(lat), 32'(FULL_LAT));
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall done held", 32'(div_done), 32'd1);
      checkOutput("stall quot held", quot, 32'd14);
      checkOutput("stall rem held", rem, 32'd2);
      checkOutput("stall no block", 32'(is_divu_block), 32'd0);
    end
    @(posedge clk);
    #1 exe_leave = 1'b1;
    @(posedge clk);
    #1;
    exe_leave = 1'b0;
    src1      = 32'd9;
    src2      = 32'd3;
    waitDone(1'b0, 1'b0, lat);
    checkOutput("b2b latency", 32'(lat), 32'(FULL_LAT));
    checkOutput("b2b quot", quot, 32'd3);
    checkOutput("b2b rem", rem, 32'd0);
    leaveExe();

    // Flush in BUSY cycle 10
    holdQ = quot;
    holdR = rem;
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    divu_req = 1'b0;
    checkAborted("flushBusy", holdQ, holdR);
    runCase("afterFlush", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    // Flush together with a request in IDLE: the request must not start
    holdQ = quot;
    holdR = rem;
    applyStimulus(1'b0, 32'd50, 32'd5);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    divu_req = 1'b0;
    checkAborted("flushIdle", holdQ, holdR);

    // Reset in BUSY cycle 20
    applyStimulus(1'b1, 32'd77, 32'd5);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    div_req = 1'b0;
    checkAborted("resetBusy", 32'd0, 32'd0);
    runCase("afterReset", 1'b1, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

    // Randomized divides against the reference model
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        3:       b = -32'($urandom_range(1, 100));
        4: begin
          a = 32'($urandom_range(0, 1000));
          b = 32'($urandom_range(1, 1000));
        end
        default: b = $urandom;
      endcase
      refDiv(sgn, a, b, q, r);
      runCase($sformatf("rand%0d", i), sgn, a, b, q, r, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
